// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtract controller: computes a - b LSB-first over W cycles
// through a one-bit subtractor slice with a registered borrow.
module serial_sub_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    sh_a;
  logic [W-1:0]    sh_b;
  logic [W-1:0]    sh_res;
  logic            brw;
  logic [CW-1:0]   cnt;

  logic            slice_d;
  logic            slice_bo;
  logic [W-1:0]    res_next;
  logic            accept;

  // One-bit subtractor slice fed by the operand LSBs and the borrow flop
  always_comb begin
    slice_d  = sh_a[0] ^ sh_b[0] ^ brw;
    slice_bo = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & brw);
    res_next = {slice_d, sh_res[W-1:1]};
    accept   = start && (state == IDLE || state == DONE);
  end

  // Sequencer; busy/done are registered alongside the state they decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      sh_a       <= '0;
      sh_b       <= '0;
      sh_res     <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            sh_a  <= a;
            sh_b  <= b;
            brw   <= 1'b0;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sh_res <= res_next;
          sh_a   <= {1'b0, sh_a[W-1:1]};
          sh_b   <= {1'b0, sh_b[W-1:1]};
          brw    <= slice_bo;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            state      <= DONE;
            done       <= 1'b1;
            diff       <= res_next;
            borrow_out <= slice_bo;
          end else begin
            busy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random checks of serial_sub_ctrl against hand-computed results.
module tb_serial_sub_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] last_diff;
  logic         last_bo;

  serial_sub_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One op: optional stray start during RUN at cycle inj (inj<0 disables)
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W-1:0] ed, input logic eb,
                        input string tag, input int inj);
    int   nb;
    logic held;
    logic seen;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0; held = 1'b1; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nb++;
      if (diff !== last_diff || borrow_out !== last_bo) held = 1'b0;
      if (i == inj) begin
        start = 1'b1; a = 8'hAA; b = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(W));
    chk({tag, "_hold"}, 32'(held), 32'd1);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
    last_diff = ed;
    last_bo   = eb;
  endtask

  initial begin
    int nd;
    int t1;
    int t2;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic         b1;
    logic         b2;
    logic [W:0]   ref_v;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    last_diff = '0; last_bo = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    rst = 1'b0;

    run_op(8'h35, 8'h12, 8'h23, 1'b0, "basic", -1);
    run_op(8'h12, 8'h35, 8'hDD, 1'b1, "neg", -1);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, "ripple", -1);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, "equal", -1);
    run_op(8'h80, 8'h7F, 8'h01, 1'b0, "msb", -1);

    // Stray start during RUN must be ignored
    run_op(8'h35, 8'h12, 8'h23, 1'b0, "ignore", 3);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("ignore_extra_done", 32'(nd), 32'd0);

    // Reset during RUN aborts without a done pulse
    @(negedge clk);
    a = 8'h40; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow_out), 32'd0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    last_diff = '0; last_bo = 1'b0;
    run_op(8'h10, 8'h01, 8'h0F, 1'b0, "after_abort", -1);

    // Start held high: back-to-back ops, second operands taken at the DONE edge
    @(negedge clk);
    a = 8'h05; b = 8'h03; start = 1'b1;
    @(negedge clk);
    a = 8'h03; b = 8'h05;
    t1 = -1; t2 = -1; d1 = '0; d2 = '0; b1 = 1'b0; b2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        if (t1 < 0) begin
          t1 = i; d1 = diff; b1 = borrow_out;
        end else begin
          t2 = i; d2 = diff; b2 = borrow_out;
          start = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_first_seen", 32'(t1 >= 0), 32'd1);
    chk("b2b_gap", 32'(t2 - t1), 32'd9);
    chk("b2b_diff1", 32'(d1), 32'h02);
    chk("b2b_borrow1", 32'(b1), 32'd0);
    chk("b2b_diff2", 32'(d2), 32'hFE);
    chk("b2b_borrow2", 32'(b2), 32'd1);
    last_diff = 8'hFE; last_bo = 1'b1;

    // Random ops against an (W+1)-bit subtraction reference
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      ref_v = {1'b0, ra} - {1'b0, rb};
      run_op(ra, rb, ref_v[W-1:0], ref_v[W], "rand", -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
